// File: rtl/pot_scan_sched.sv
// pot_scan_sched
// Round-robin owner of the shared slide-pot A2D interface. Sweeps the five
// band-gain pots and the volume pot, keeps the latest 12-bit result per slot
// and declares the settings valid once every slot has been read.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   en              scan enable (checked in IDLE and at each slot advance)
//   strt_cnv        one-cycle conversion request to the A2D interface
//   chnnl[2:0]      A2D channel for the current request (held ISSUE..WAIT)
//   cnv_cmplt       one-cycle conversion-done strobe, qualifies res
//   res[11:0]       conversion result
//   lp/b1/b2/b3/hp_gain[11:0], volume[11:0]  latest result per slot
//   cur_slot[2:0]   slot being serviced (0..5)
//   sweep_done      one-cycle pulse after the last slot of a sweep
//   all_valid       sticky: every slot captured at least once
//   timeout_err     sticky: a conversion timed out
module pot_scan_sched #(
  parameter int unsigned SCAN_PERIOD = 2048,
  parameter int unsigned CNV_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] lp_gain,
  output logic [11:0] b1_gain,
  output logic [11:0] b2_gain,
  output logic [11:0] b3_gain,
  output logic [11:0] hp_gain,
  output logic [11:0] volume,
  output logic [2:0]  cur_slot,
  output logic        sweep_done,
  output logic        all_valid,
  output logic        timeout_err
);

  localparam int unsigned NSLOT = 6;
  localparam int unsigned PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned TW = (CNV_TIMEOUT > 1) ? $clog2(CNV_TIMEOUT) : 1;
  localparam logic [2:0]  LAST_SLOT = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    slot_q, slot_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          first_q, first_d;
  logic [5:0]    captured_q, captured_d;
  logic [11:0]   gain_q [NSLOT];
  logic [11:0]   gain_d [NSLOT];
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          strt_q, strt_d;
  logic [2:0]    chnnl_q, chnnl_d;
  logic          advance;

  // Board wiring of the pots onto the A2D mux.
  function automatic logic [2:0] slot_chnnl(input logic [2:0] s);
    logic [2:0] c;
    case (s)
      3'd0:    c = 3'd1;
      3'd1:    c = 3'd0;
      3'd2:    c = 3'd4;
      3'd3:    c = 3'd2;
      3'd4:    c = 3'd3;
      3'd5:    c = 3'd7;
      default: c = 3'd0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    pcnt_d     = pcnt_q;
    tcnt_d     = tcnt_q;
    first_d    = first_q;
    captured_d = captured_q;
    gain_d     = gain_q;
    err_d      = err_q;
    done_d     = 1'b0;
    chnnl_d    = chnnl_q;
    advance    = 1'b0;
    // One cycle behind captured, so all_valid trails the final capture.
    valid_d    = valid_q | (&captured_q);

    case (state_q)
      S_IDLE: begin
        if (!en) begin
          pcnt_d = '0;
        end else if (first_q) begin
          first_d = 1'b0;
          slot_d  = '0;
          state_d = S_ISSUE;
        end else if (pcnt_q == PW'(SCAN_PERIOD - 1)) begin
          pcnt_d  = '0;
          slot_d  = '0;
          state_d = S_ISSUE;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      S_ISSUE: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        // A completion on the expiry cycle still counts as a capture.
        if (cnv_cmplt) begin
          for (int unsigned i = 0; i < NSLOT; i++) begin
            if (slot_q == 3'(i)) begin
              gain_d[i]     = res;
              captured_d[i] = 1'b1;
            end
          end
          advance = 1'b1;
        end else if (tcnt_q == TW'(CNV_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          advance = 1'b1;
        end
        if (advance) begin
          if (slot_q == LAST_SLOT) begin
            done_d  = 1'b1;
            slot_d  = '0;
            state_d = S_IDLE;
          end else if (en) begin
            slot_d  = slot_q + 3'd1;
            state_d = S_ISSUE;
          end else begin
            slot_d  = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        slot_d  = '0;
      end
    endcase

    // Request and channel are registered on entry to ISSUE so the channel
    // stays put for the whole ISSUE/WAIT window.
    strt_d = (state_d == S_ISSUE);
    if (state_d == S_ISSUE) begin
      chnnl_d = slot_chnnl(slot_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      pcnt_q     <= '0;
      tcnt_q     <= '0;
      first_q    <= 1'b1;
      captured_q <= '0;
      for (int unsigned i = 0; i < NSLOT - 1; i++) begin
        gain_q[i] <= 12'h800;
      end
      gain_q[NSLOT-1] <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      strt_q     <= 1'b0;
      chnnl_q    <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      pcnt_q     <= pcnt_d;
      tcnt_q     <= tcnt_d;
      first_q    <= first_d;
      captured_q <= captured_d;
      gain_q     <= gain_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      strt_q     <= strt_d;
      chnnl_q    <= chnnl_d;
    end
  end

  assign strt_cnv    = strt_q;
  assign chnnl       = chnnl_q;
  assign cur_slot    = slot_q;
  assign lp_gain     = gain_q[0];
  assign b1_gain     = gain_q[1];
  assign b2_gain     = gain_q[2];
  assign b3_gain     = gain_q[3];
  assign hp_gain     = gain_q[4];
  assign volume      = gain_q[5];
  assign sweep_done  = done_q;
  assign all_valid   = valid_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_pot_scan_sched.sv
// Self-checking bench for pot_scan_sched: table of slot-0 response delays,
// hand-written multi-cycle sequences, and randomized sweeps checked against
// a transaction-level model (per-slot capture/timeout rules and sweep length).
module tb_pot_scan_sched;

  localparam int unsigned SP = 64;
  localparam int unsigned CT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = '0;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] lp_gain, b1_gain, b2_gain, b3_gain, hp_gain, volume;
  logic [2:0]  cur_slot;
  logic        sweep_done, all_valid, timeout_err;

  pot_scan_sched #(.SCAN_PERIOD(SP), .CNV_TIMEOUT(CT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res),
    .lp_gain(lp_gain), .b1_gain(b1_gain), .b2_gain(b2_gain),
    .b3_gain(b3_gain), .hp_gain(hp_gain), .volume(volume),
    .cur_slot(cur_slot), .sweep_done(sweep_done),
    .all_valid(all_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct { int cyc; int ch; } req_t;
  req_t strt_q[$];
  int   done_q[$];

  // A2D model: per-channel response delay in cycles after the request
  // (0 = never answers).
  int unsigned dly [8];
  logic        rand_res = 1'b0;
  logic [11:0] sent_val [8];
  logic        pend = 1'b0;
  int          due = 0;
  logic [11:0] pval = '0;

  function automatic int chmap(input int s);
    case (s)
      0: return 1;
      1: return 0;
      2: return 4;
      3: return 2;
      4: return 3;
      default: return 7;
    endcase
  endfunction

  function automatic logic [11:0] gain_of(input int s);
    case (s)
      0: return lp_gain;
      1: return b1_gain;
      2: return b2_gain;
      3: return b3_gain;
      4: return hp_gain;
      default: return volume;
    endcase
  endfunction

  // Monitor + A2D responder, sampling 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      cnv_cmplt = 1'b0;
      if (pend && cyc == due) begin
        cnv_cmplt = 1'b1;
        res       = pval;
        pend      = 1'b0;
      end
      if (strt_cnv) begin
        req_t ev;
        ev.cyc = cyc;
        ev.ch  = int'(chnnl);
        strt_q.push_back(ev);
        if (dly[chnnl] != 0) begin
          pend = 1'b1;
          due  = cyc + int'(dly[chnnl]);
          pval = rand_res ? 12'($urandom) : (12'h100 + 12'(chnnl));
          sent_val[chnnl] = pval;
        end else begin
          pend = 1'b0;
        end
      end
      if (sweep_done) done_q.push_back(cyc);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic en_v, output int c0);
    pend = 1'b0;
    en   = en_v;
    rst  = 1'b1;
    tick();
    tick();
    strt_q.delete();
    done_q.delete();
    rst = 1'b0;
    c0  = cyc;
  endtask

  task automatic wait_done(input string nm, input int budget, output int dc);
    int n = 0;
    while (done_q.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    check({nm, "_sweep_done_seen"}, done_q.size() != 0, 1);
    dc = (done_q.size() != 0) ? done_q[0] : -1;
  endtask

  task automatic wait_strt(input string nm, input int n_req, input int budget);
    int n = 0;
    while (strt_q.size() < n_req && n < budget) begin
      tick();
      n++;
    end
    check({nm, "_strt_seen"}, strt_q.size() >= n_req, 1);
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_strt_cnv"}, strt_cnv, 0);
    check({nm, "_chnnl"}, chnnl, 0);
    check({nm, "_cur_slot"}, cur_slot, 0);
    for (int s = 0; s < 5; s++) check({nm, "_gain"}, gain_of(s), 12'h800);
    check({nm, "_volume"}, volume, 12'h000);
    check({nm, "_sweep_done"}, sweep_done, 0);
    check({nm, "_all_valid"}, all_valid, 0);
    check({nm, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic set_dly(input int unsigned d);
    for (int c = 0; c < 8; c++) dly[c] = d;
  endtask

  typedef struct {
    int unsigned dly;
    logic [11:0] exp_lp;
    logic        exp_err;
    int          exp_gap;
  } vec_t;

  initial begin
    int c0, dc, dc2, e, n, k;
    vec_t vecs[6];
    logic [11:0] mval [6];
    logic [5:0]  mcap;
    logic        merr;
    int          dur;

    vecs[0] = '{1,  12'h101, 1'b0, 2};
    vecs[1] = '{5,  12'h101, 1'b0, 6};
    vecs[2] = '{31, 12'h101, 1'b0, 32};
    vecs[3] = '{32, 12'h101, 1'b0, 33};
    vecs[4] = '{33, 12'h800, 1'b1, 33};
    vecs[5] = '{0,  12'h800, 1'b1, 33};

    set_dly(5);

    // Reset values with en low.
    do_reset(1'b0, c0);
    check_reset("rst0");
    tick();
    check_reset("rst0_idle");
    check("rst0_no_req", strt_q.size(), 0);

    // First sweep right after reset release.
    do_reset(1'b1, c0);
    wait_done("t1", 200, dc);
    check("t1_req_count", strt_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < strt_q.size()) begin
        check("t1_req_chnnl", strt_q[i].ch, chmap(i));
        check("t1_req_cycle", strt_q[i].cyc, c0 + 1 + 6 * i);
      end
    end
    check("t1_done_cycle", dc, c0 + 37);
    for (int s = 0; s < 6; s++) check("t1_gain", gain_of(s), 12'h100 + 12'(chmap(s)));
    check("t1_valid_at_done", all_valid, 0);
    check("t1_done_high", sweep_done, 1);
    tick();
    check("t1_valid_after", all_valid, 1);
    check("t1_done_pulse", sweep_done, 0);
    check("t1_done_count", done_q.size(), 1);
    check("t1_err", timeout_err, 0);

    // Steady-state period, then en low holds the scheduler in IDLE.
    done_q.delete();
    wait_strt("t2", 7, 100);
    if (strt_q.size() >= 7) begin
      check("t2_period", strt_q[6].cyc, dc + 64);
      check("t2_chnnl", strt_q[6].ch, 1);
    end
    wait_done("t2", 200, dc2);
    en = 1'b0;
    n = strt_q.size();
    repeat (150) tick();
    check("t2_en_low_no_req", strt_q.size(), n);
    check("t2_en_low_slot", cur_slot, 0);
    en = 1'b1;
    e = cyc;
    wait_strt("t2_resume", n + 1, 100);
    if (strt_q.size() > n) check("t2_resume_cycle", strt_q[n].cyc, e + 64);
    en = 1'b0;

    // Channel 4 never answers: slot 2 times out, sweep continues.
    set_dly(5);
    dly[4] = 0;
    do_reset(1'b1, c0);
    wait_done("t3", 300, dc);
    check("t3_req_count", strt_q.size(), 6);
    if (strt_q.size() >= 4) begin
      check("t3_wait_len", strt_q[3].cyc - strt_q[2].cyc, 33);
      check("t3_next_chnnl", strt_q[3].ch, 2);
    end
    check("t3_done_cycle", dc, c0 + 64);
    check("t3_b2", b2_gain, 12'h800);
    check("t3_b3", b3_gain, 12'h102);
    check("t3_err", timeout_err, 1);
    tick();
    check("t3_valid", all_valid, 0);
    set_dly(5);

    // Table: slot-0 response delay around the timeout boundary.
    for (int v = 0; v < 6; v++) begin
      set_dly(5);
      dly[1] = vecs[v].dly;
      do_reset(1'b1, c0);
      wait_done("tv", 300, dc);
      if (strt_q.size() >= 2) begin
        check("tv_gap", strt_q[1].cyc - strt_q[0].cyc, vecs[v].exp_gap);
        check("tv_ch1", strt_q[1].ch, 0);
      end
      check("tv_lp", lp_gain, vecs[v].exp_lp);
      check("tv_b1", b1_gain, 12'h100);
      check("tv_err", timeout_err, vecs[v].exp_err);
      tick();
      check("tv_valid", all_valid, !vecs[v].exp_err);
    end
    set_dly(5);

    // en dropped during the WAIT of slot 2.
    do_reset(1'b1, c0);
    wait_strt("t5", 3, 100);
    tick();
    en = 1'b0;
    repeat (20) tick();
    check("t5_b2_captured", b2_gain, 12'h104);
    check("t5_no_ch2_req", strt_q.size(), 3);
    check("t5_no_done", done_q.size(), 0);
    check("t5_slot", cur_slot, 0);
    check("t5_strt", strt_cnv, 0);
    check("t5_b3", b3_gain, 12'h800);

    // rst during slot 3 WAIT, then a late strobe arrives in IDLE.
    dly[2] = 8;
    do_reset(1'b1, c0);
    wait_strt("t6", 4, 100);
    k = cyc;
    tick();
    tick();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    while (cyc < k + 10) tick();
    check_reset("t6");
    check("t6_req_count", strt_q.size(), 4);

    // Randomized sweeps against the transaction-level model.
    rand_res = 1'b1;
    for (int s = 0; s < 6; s++) mval[s] = (s == 5) ? 12'h000 : 12'h800;
    mcap = '0;
    merr = 1'b0;
    for (int c = 0; c < 8; c++)
      dly[c] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
    do_reset(1'b1, c0);
    for (int sw = 0; sw < 6; sw++) begin
      wait_done("rnd", 500, dc);
      dur = 0;
      for (int s = 0; s < 6; s++) begin
        int ch;
        ch = chmap(s);
        if (dly[ch] != 0 && dly[ch] <= CT) begin
          mval[s] = sent_val[ch];
          mcap[s] = 1'b1;
          dur += int'(dly[ch]) + 1;
        end else begin
          merr = 1'b1;
          dur += int'(CT) + 1;
        end
      end
      check("rnd_req_count", strt_q.size(), 6);
      for (int i = 0; i < 6; i++)
        if (i < strt_q.size()) check("rnd_req_chnnl", strt_q[i].ch, chmap(i));
      if (strt_q.size() > 0) check("rnd_sweep_len", dc - strt_q[0].cyc, dur);
      for (int s = 0; s < 6; s++) check("rnd_gain", gain_of(s), mval[s]);
      check("rnd_err", timeout_err, merr);
      tick();
      check("rnd_valid", all_valid, &mcap);
      strt_q.delete();
      done_q.delete();
      for (int c = 0; c < 8; c++)
        dly[c] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
